// File: rtl/ripple_carry_adder.sv
// Registered ripple-carry adder: a chain of one-bit full-adder cells
// feeding a single output register with valid, carry and signed overflow.

module rca_cell (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    logic p;

    assign p     = a ^ b;
    assign s     = p ^ c_in;
    assign c_out = (a & b) | (c_in & p);

endmodule

module ripple_carry_adder #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             out_valid,
    output logic             overflow
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] s_comb;

    assign carry[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        rca_cell u_cell (
            .a     (a[i]),
            .b     (b[i]),
            .c_in  (carry[i]),
            .s     (s_comb[i]),
            .c_out (carry[i+1])
        );
    end

    // Result registers hold their value on idle cycles; only out_valid pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            c_out     <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum      <= s_comb;
                c_out    <= carry[WIDTH];
                overflow <= carry[WIDTH] ^ carry[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench for ripple_carry_adder at WIDTH 1, 2 and 8
// against a signed/unsigned arithmetic reference model.

module tb_ripple_carry_adder;

    logic clk;
    logic rst;

    logic [1:0] a2, b2, s2;
    logic       ci2, v2, co2, ov2, vo2;

    logic [7:0] a8, b8, s8;
    logic       ci8, v8, co8, ov8, vo8;

    logic [0:0] a1, b1, s1;
    logic       ci1, v1, co1, ov1, vo1;

    int compared;
    int mismatched;

    longint e_s;
    int     e_c;
    int     e_o;

    ripple_carry_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .a(a2), .b(b2), .c_in(ci2),
        .in_valid(v2), .sum(s2), .c_out(co2),
        .out_valid(vo2), .overflow(ov2)
    );

    ripple_carry_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .c_in(ci8),
        .in_valid(v8), .sum(s8), .c_out(co8),
        .out_valid(vo8), .overflow(ov8)
    );

    ripple_carry_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .c_in(ci1),
        .in_valid(v1), .sum(s1), .c_out(co1),
        .out_valid(vo1), .overflow(ov1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unsigned sum plus two's-complement range check for overflow.
    function automatic void ref_add(
        input int w, input longint a, input longint b, input int cin,
        output longint s, output int co, output int ov
    );
        longint one, full, sa, sb, sr, hi, lo;
        one  = 1;
        full = a + b + cin;
        s    = full & ((one << w) - 1);
        co   = int'((full >> w) & 1);
        sa   = (a >= (one << (w - 1))) ? a - (one << w) : a;
        sb   = (b >= (one << (w - 1))) ? b - (one << w) : b;
        sr   = sa + sb + cin;
        hi   = (one << (w - 1)) - 1;
        lo   = -(one << (w - 1));
        ov   = (sr > hi || sr < lo) ? 1 : 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        v2 = 1'b1; a2 = 2'b11; b2 = 2'b11; ci2 = 1'b1;
        v8 = 1'b1; a8 = 8'hff; b8 = 8'h81; ci8 = 1'b1;
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            compared += 3;
            if ({s2, co2, ov2, vo2} !== 5'b0) begin
                mismatched++;
                $display("FAIL reset_w2 got %b want 00000", {s2, co2, ov2, vo2});
            end
            if ({s8, co8, ov8, vo8} !== 11'b0) begin
                mismatched++;
                $display("FAIL reset_w8 got %b want 0", {s8, co8, ov8, vo8});
            end
            if ({s1, co1, ov1, vo1} !== 4'b0) begin
                mismatched++;
                $display("FAIL reset_w1 got %b want 0000", {s1, co1, ov1, vo1});
            end
        end
        rst = 1'b0;
        v2 = 1'b0; v8 = 1'b0; v1 = 1'b0;
        tick();
        compared++;
        if (vo2 !== 1'b0 || s2 !== 2'b0) begin
            mismatched++;
            $display("FAIL reset_idle got vo=%b s=%b want 0 00", vo2, s2);
        end
    endtask

    task automatic test_directed();
        logic [1:0] ta [5] = '{2'd1, 2'd3, 2'd2, 2'd0, 2'd1};
        logic [1:0] tb [5] = '{2'd3, 2'd3, 2'd1, 2'd3, 2'd1};
        logic       tc [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [1:0] xs [5] = '{2'd1, 2'd3, 2'd3, 2'd3, 2'd2};
        logic       xc [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       xo [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 5; k++) begin
            a2 = ta[k]; b2 = tb[k]; ci2 = tc[k]; v2 = 1'b1;
            tick();
            compared++;
            if (s2 !== xs[k] || co2 !== xc[k] || ov2 !== xo[k] || vo2 !== 1'b1) begin
                mismatched++;
                $display("FAIL directed_%0d got s=%b c=%b ov=%b v=%b want s=%b c=%b ov=%b v=1",
                         k, s2, co2, ov2, vo2, xs[k], xc[k], xo[k]);
            end
        end
        e_s = 2; e_c = 0; e_o = 1;
    endtask

    task automatic test_hold();
        v2 = 1'b0; a2 = 2'd3; b2 = 2'd3; ci2 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            compared++;
            if (s2 !== 2'(e_s) || co2 !== 1'(e_c) || ov2 !== 1'(e_o) || vo2 !== 1'b0) begin
                mismatched++;
                $display("FAIL hold_%0d got s=%b c=%b ov=%b v=%b want s=%0d c=%0d ov=%0d v=0",
                         k, s2, co2, ov2, vo2, e_s, e_c, e_o);
            end
        end
    endtask

    task automatic test_reset_mid();
        a2 = 2'd3; b2 = 2'd3; ci2 = 1'b1; v2 = 1'b1;
        tick();
        rst = 1'b1;
        a2 = 2'd1; b2 = 2'd1; ci2 = 1'b0;
        tick();
        compared++;
        if ({s2, co2, ov2, vo2} !== 5'b0) begin
            mismatched++;
            $display("FAIL reset_mid got %b want 00000", {s2, co2, ov2, vo2});
        end
        rst = 1'b0;
        a2 = 2'd2; b2 = 2'd3; ci2 = 1'b1; v2 = 1'b1;
        tick();
        ref_add(2, 2, 3, 1, e_s, e_c, e_o);
        compared++;
        if (s2 !== 2'(e_s) || co2 !== 1'(e_c) || ov2 !== 1'(e_o) || vo2 !== 1'b1) begin
            mismatched++;
            $display("FAIL after_reset got s=%b c=%b ov=%b v=%b want s=%0d c=%0d ov=%0d v=1",
                     s2, co2, ov2, vo2, e_s, e_c, e_o);
        end
        v2 = 1'b0;
        tick();
    endtask

    task automatic test_exhaustive_w2();
        for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++)
                for (int c = 0; c < 2; c++) begin
                    a2 = 2'(x); b2 = 2'(y); ci2 = 1'(c); v2 = 1'b1;
                    tick();
                    ref_add(2, x, y, c, e_s, e_c, e_o);
                    compared++;
                    if (s2 !== 2'(e_s) || co2 !== 1'(e_c) || ov2 !== 1'(e_o) || vo2 !== 1'b1) begin
                        mismatched++;
                        $display("FAIL sweep_w2 %0d+%0d+%0d got s=%b c=%b ov=%b v=%b want s=%0d c=%0d ov=%0d v=1",
                                 x, y, c, s2, co2, ov2, vo2, e_s, e_c, e_o);
                    end
                end
        v2 = 1'b0;
    endtask

    task automatic test_exhaustive_w1();
        for (int x = 0; x < 2; x++)
            for (int y = 0; y < 2; y++)
                for (int c = 0; c < 2; c++) begin
                    a1 = 1'(x); b1 = 1'(y); ci1 = 1'(c); v1 = 1'b1;
                    tick();
                    ref_add(1, x, y, c, e_s, e_c, e_o);
                    compared++;
                    if (s1 !== 1'(e_s) || co1 !== 1'(e_c) || ov1 !== 1'(e_o) || vo1 !== 1'b1) begin
                        mismatched++;
                        $display("FAIL sweep_w1 %0d+%0d+%0d got s=%b c=%b ov=%b v=%b want s=%0d c=%0d ov=%0d v=1",
                                 x, y, c, s1, co1, ov1, vo1, e_s, e_c, e_o);
                    end
                end
        v1 = 1'b0;
    endtask

    task automatic test_random_w8();
        int x, y, c;
        for (int k = 0; k < 300; k++) begin
            x = int'($urandom_range(255));
            y = int'($urandom_range(255));
            c = int'($urandom_range(1));
            a8 = 8'(x); b8 = 8'(y); ci8 = 1'(c); v8 = 1'b1;
            tick();
            ref_add(8, x, y, c, e_s, e_c, e_o);
            compared++;
            if (s8 !== 8'(e_s) || co8 !== 1'(e_c) || ov8 !== 1'(e_o) || vo8 !== 1'b1) begin
                mismatched++;
                $display("FAIL rand_w8 %0d+%0d+%0d got s=%0d c=%b ov=%b v=%b want s=%0d c=%0d ov=%0d v=1",
                         x, y, c, s8, co8, ov8, vo8, e_s, e_c, e_o);
            end
        end
    endtask

    task automatic test_gaps_w8();
        int x, y, c, vv;
        for (int k = 0; k < 200; k++) begin
            x  = int'($urandom_range(255));
            y  = int'($urandom_range(255));
            c  = int'($urandom_range(1));
            vv = int'($urandom_range(1));
            a8 = 8'(x); b8 = 8'(y); ci8 = 1'(c); v8 = 1'(vv);
            tick();
            if (vv == 1) ref_add(8, x, y, c, e_s, e_c, e_o);
            compared++;
            if (s8 !== 8'(e_s) || co8 !== 1'(e_c) || ov8 !== 1'(e_o) || vo8 !== 1'(vv)) begin
                mismatched++;
                $display("FAIL gaps_w8 step %0d got s=%0d c=%b ov=%b v=%b want s=%0d c=%0d ov=%0d v=%0d",
                         k, s8, co8, ov8, vo8, e_s, e_c, e_o, vv);
            end
        end
        v8 = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst = 1'b1;
        a2 = '0; b2 = '0; ci2 = 1'b0; v2 = 1'b0;
        a8 = '0; b8 = '0; ci8 = 1'b0; v8 = 1'b0;
        a1 = '0; b1 = '0; ci1 = 1'b0; v1 = 1'b0;
        tick();
        test_reset();
        test_directed();
        test_hold();
        test_reset_mid();
        test_exhaustive_w2();
        test_exhaustive_w1();
        test_random_w8();
        test_gaps_w8();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
